// File: rtl/duty_ctrl_pkg.sv
// duty_ctrl_pkg: shared constants, FSM state type and the duty step helper for duty_ramp_ctrl.
package duty_ctrl_pkg;
    localparam int NCH    = 3;
    localparam int DUTY_W = 8;
    // Must track the duty register's own reset values so the shadow starts in sync.
    localparam logic [DUTY_W-1:0] RST_DUTY0 = 8'd64;
    localparam logic [DUTY_W-1:0] RST_DUTY1 = 8'd128;
    localparam logic [DUTY_W-1:0] RST_DUTY2 = 8'd192;
    typedef enum logic [1:0] {IDLE, WR0, WR1, WR2} state_t;
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt,
                                                      input logic [DUTY_W-1:0] step);
        logic signed [DUTY_W:0] diff;
        logic signed [DUTY_W:0] lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        lim  = $signed({1'b0, step});
        // A full step would overshoot only when |diff| <= step, so no wrap is possible.
        return (diff <= lim && diff >= -lim) ? tgt : (diff > 0) ? cur + step : cur - step;
    endfunction
endpackage

// File: rtl/duty_ramp_ctrl_if.sv
// duty_ramp_ctrl_if: request handshake and duty register write port of duty_ramp_ctrl.
interface duty_ramp_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_ch;
    logic [7:0] req_target;
    logic       we;
    logic [1:0] ch_sel;
    logic [7:0] duty_in;
    modport master (output req_valid, req_ch, req_target, input req_ready, we, ch_sel, duty_in);
    modport slave  (input req_valid, req_ch, req_target, output req_ready, we, ch_sel, duty_in);
endinterface

// File: rtl/duty_tick_gen.sv
// duty_tick_gen: TICK_DIV prescaler; one-cycle tick on the last count, counter held at 0 when disabled.
module duty_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = en && cnt_q == CW'(TICK_DIV - 1);
    always_comb cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: soft-start sequencer stepping three PWM duty channels toward their targets.
// Optional DUTY_RAMP_DONE_IRQ_EN adds the done_irq/done_ch completion pulse.
module duty_ramp_ctrl
    import duty_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int STEP     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ramp_en,
    duty_ramp_ctrl_if.slave      bus,
    output logic [NCH-1:0]       busy
`ifdef DUTY_RAMP_DONE_IRQ_EN
    ,
    output logic                 done_irq,
    output logic [1:0]           done_ch
`endif
);
    logic              tick;
    state_t            state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic              pend_q, pend_d;
    logic [NCH-1:0]    busy_q, busy_d;
    logic [DUTY_W-1:0] tgt_q [NCH];
    logic [DUTY_W-1:0] tgt_d [NCH];
    logic [DUTY_W-1:0] shd_q [NCH];
    logic [DUTY_W-1:0] shd_d [NCH];
    logic              we_q, we_d;
    logic [1:0]        ch_sel_q, ch_sel_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic [1:0]        k, c;
    logic [2:0]        rs;
    logic [DUTY_W-1:0] nxt;
`ifdef DUTY_RAMP_DONE_IRQ_EN
    logic              done_irq_q, done_irq_d;
    logic [1:0]        done_ch_q, done_ch_d;
    assign done_irq = done_irq_q;
    assign done_ch  = done_ch_q;
`endif

    duty_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .en(ramp_en), .tick(tick));

    assign bus.req_ready = ready_q;
    assign bus.we        = we_q;
    assign bus.ch_sel    = ch_sel_q;
    assign bus.duty_in   = duty_q;
    assign busy          = busy_q;

    always_comb begin
        tgt_d    = tgt_q;
        shd_d    = shd_q;
        busy_d   = busy_q;
        rr_d     = rr_q;
        we_d     = 1'b0;
        ch_sel_d = ch_sel_q;
        duty_d   = duty_q;
        nxt      = '0;
`ifdef DUTY_RAMP_DONE_IRQ_EN
        done_irq_d = 1'b0;
        done_ch_d  = done_ch_q;
`endif
        // Channel 3 is handshaken but otherwise ignored.
        accept = bus.req_valid && ready_q && bus.req_ch != 2'd3;
        if (accept) begin
            tgt_d[bus.req_ch]  = bus.req_target;
            busy_d[bus.req_ch] = bus.req_target != shd_q[bus.req_ch];
`ifdef DUTY_RAMP_DONE_IRQ_EN
            done_irq_d = bus.req_target == shd_q[bus.req_ch];
            done_ch_d  = bus.req_ch;
`endif
        end
        if (state_q == IDLE) begin
            pend_d  = 1'b0;
            state_d = ((tick || pend_q) && busy_d != '0) ? WR0 : IDLE;
        end else begin
            pend_d  = pend_q || tick;
            state_d = (state_q == WR2) ? IDLE : state_t'(2'(state_q) + 2'd1);
        end
        // The write for WRk is prepared on the edge entering WRk so outputs stay registered.
        k  = 2'(state_d) - 2'd1;
        rs = {1'b0, rr_q} + {1'b0, k};
        c  = (rs >= 3'd3) ? 2'(rs - 3'd3) : rs[1:0];
        if (state_d != IDLE && busy_d[c]) begin
            nxt      = step_toward(shd_q[c], tgt_d[c], DUTY_W'(STEP));
            we_d     = 1'b1;
            ch_sel_d = c;
            duty_d   = nxt;
            shd_d[c] = nxt;
            if (nxt == tgt_d[c]) begin
                busy_d[c] = 1'b0;
`ifdef DUTY_RAMP_DONE_IRQ_EN
                done_irq_d = 1'b1;
                done_ch_d  = c;
`endif
            end
        end
        if (state_q == WR2) rr_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            pend_q   <= 1'b0;
            busy_q   <= '0;
            tgt_q    <= '{RST_DUTY0, RST_DUTY1, RST_DUTY2};
            shd_q    <= '{RST_DUTY0, RST_DUTY1, RST_DUTY2};
            we_q     <= 1'b0;
            ch_sel_q <= '0;
            duty_q   <= '0;
            ready_q  <= 1'b1;
`ifdef DUTY_RAMP_DONE_IRQ_EN
            done_irq_q <= 1'b0;
            done_ch_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            tgt_q    <= tgt_d;
            shd_q    <= shd_d;
            we_q     <= we_d;
            ch_sel_q <= ch_sel_d;
            duty_q   <= duty_d;
            ready_q  <= ready_d;
`ifdef DUTY_RAMP_DONE_IRQ_EN
            done_irq_q <= done_irq_d;
            done_ch_q  <= done_ch_d;
`endif
        end
    end
endmodule
